// File: rtl/word_serializer.sv
// Parallel-to-serial word transmitter with frame-start marker and one-word holding buffer.
// Optional build macro SER_PARITY_EN appends an even-parity bit to every frame.
module word_serializer #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic             start_new;
  logic [WIDTH-1:0] new_word;

  logic             emit;
  logic [WIDTH-1:0] src_word;
  logic [CNT_W-1:0] src_idx;
  logic             out_n;
  logic             out_valid_n;
  logic             frame_start_n;

  // The shift register keeps the word unshifted; the counter selects the bit on air.
  function automatic logic bit_of(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] idx);
    logic [WIDTH-1:0] ord;
    logic [WIDTH-1:0] sh;
    if (MSB_FIRST) ord = {<<{w}};
    else           ord = w;
    sh = ord >> idx;
    return sh[0];
  endfunction

  assign load_ready = ~hold_full;
  assign busy       = (state == SHIFT) | hold_full;
  assign accept     = load_valid & ~hold_full;
  assign last       = (state == SHIFT) && (cnt == LAST);
  assign start_new  = ((state == IDLE) && accept) || (last && (hold_full || accept));
  assign new_word   = (last && hold_full) ? hold : load_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = SHIFT;
      SHIFT: if (last && !(hold_full || accept)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next registered output values: the first bit comes straight from the incoming word
  // so it appears the cycle after the accept.
  always_comb begin
    emit     = 1'b0;
    src_word = shreg;
    src_idx  = cnt + CNT_W'(1);
    if (start_new) begin
      emit     = 1'b1;
      src_word = new_word;
      src_idx  = '0;
    end else if ((state == SHIFT) && !last) begin
      emit = 1'b1;
    end
`ifdef SER_PARITY_EN
    if (src_idx == CNT_W'(WIDTH)) out_n = emit & (^src_word);
    else
`endif
    out_n = emit & bit_of(src_word, src_idx);
    out_valid_n   = emit;
    frame_start_n = start_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      out         <= out_n;
      out_valid   <= out_valid_n;
      frame_start <= frame_start_n;

      if (start_new) begin
        shreg <= new_word;
        cnt   <= '0;
      end else if ((state == SHIFT) && !last) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      if ((state == SHIFT) && !last && accept) begin
        hold      <= load_data;
        hold_full <= 1'b1;
      end else if (last && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Randomized scoreboard bench for word_serializer: MSB-first and LSB-first instances share stimulus.
module tb_word_serializer;
  localparam int WIDTH = 3;
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0] load_data = '0;
  logic load_valid = 1'b0;
  logic ready_a, out_a, vld_a, fs_a, busy_a;
  logic ready_b, out_b, vld_b, fs_b, busy_b;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Each entry is {frame_start, bit}.
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_a), .out(out_a), .out_valid(vld_a), .frame_start(fs_a), .busy(busy_a));

  word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_b), .out(out_b), .out_valid(vld_b), .frame_start(fs_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame is the word's bits in transmit order, then optional even parity.
  function automatic logic model_bit(input logic [WIDTH-1:0] w, input int i, input bit msb);
    logic [WIDTH-1:0] tmp;
    if (i == WIDTH) return logic'($countones(w) % 2);
    tmp = w >> (msb ? (WIDTH - 1 - i) : i);
    return tmp[0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else if (load_valid && ready_a) begin
      for (int i = 0; i < FRAME; i++) begin
        qa.push_back({i == 0, model_bit(load_data, i, 1'b1)});
        qb.push_back({i == 0, model_bit(load_data, i, 1'b0)});
      end
    end
  end

  // The serializer never stalls with work pending, so valid tracks a non-empty queue,
  // and the hold buffer is full exactly when more than one frame remains.
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      chk("a_valid", vld_a, qa.size() > 0);
      chk("a_busy", busy_a, qa.size() > 0);
      chk("a_ready", ready_a, qa.size() <= FRAME);
      if (vld_a && qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_out", out_a, e[0]);
        chk("a_frame_start", fs_a, e[1]);
      end else if (!vld_a) begin
        chk("a_idle_out", {fs_a, out_a}, 2'b00);
      end
      chk("b_valid", vld_b, qb.size() > 0);
      chk("b_busy", busy_b, qb.size() > 0);
      chk("b_ready", ready_b, qb.size() <= FRAME);
      if (vld_b && qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_out", out_b, e[0]);
        chk("b_frame_start", fs_b, e[1]);
      end else if (!vld_b) begin
        chk("b_idle_out", {fs_b, out_b}, 2'b00);
      end
    end
  end

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit done = 1'b0;
    load_valid = 1'b1;
    load_data  = w;
    for (int k = 0; k < 20; k++) begin
      done = ready_a;
      @(posedge clk);
      #2;
      if (done) break;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 3'b111;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    chk("reset_ready", ready_a, 1'b1);
    chk("reset_valid", vld_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_out", out_a, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    send(3'b101); idle(FRAME + 3);
    send(3'b101); send(3'b110); idle(2 * FRAME + 3);
    send(3'b001); send(3'b010); send(3'b100); idle(3 * FRAME + 3);
    send(3'b110); idle(FRAME + 3);
    send(3'b100); send(3'b011); idle(2 * FRAME + 3);

    // Reset mid-frame with a word buffered: nothing of either word may resume.
    send(3'b111); send(3'b000);
    rst = 1'b1;
    load_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_valid", vld_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_ready", ready_a, 1'b1);
    chk("midrst_out", out_a, 1'b0);
    rst = 1'b0;
    send(3'b010); idle(FRAME + 3);

    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = WIDTH'($urandom);
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    idle(3 * FRAME + 5);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
